// File: rtl/tpuv2_pkg.sv
// tpuv2 sequencer shared definitions.
// FSM states, MMIO addresses, status-word and control-word bit positions.
package tpuv2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RUN,
      DONE
   } state_t;

   localparam logic [15:0] CTRL_ADDR = 16'h0400;
   localparam logic [15:0] STAT_ADDR = 16'h0408;

   // status word layout
   localparam int K_LSB    = 0;
   localparam int K_W      = 8;
   localparam int ACC_BIT  = 8;
   localparam int BUSY_BIT = 9;
   localparam int DONE_BIT = 10;
   localparam int ERR_BIT  = 11;

   // control word layout
   localparam int CTRL_K_LSB   = 0;
   localparam int CTRL_K_W     = 8;
   localparam int CTRL_ACC_BIT = 8;

endpackage

// File: rtl/tpuv2_mmio_regs.sv
// tpuv2 MMIO register block: control decode, K/acc latch, sticky flags,
// registered status read.
// Ports: clk, rst (sync, high); addr/r_w/dataIn MMIO bus; idle/busy/done
// from the sequencer; start pulse, latched k/acc; stat_data/stat_valid.
module tpuv2_mmio_regs #(
   parameter int                ADDRW     = 16,
   parameter int                DATAW     = 64,
   parameter int                MAX_K     = 64,
   parameter logic [ADDRW-1:0]  CTRL_ADDR = ADDRW'(tpuv2_pkg::CTRL_ADDR),
   parameter logic [ADDRW-1:0]  STAT_ADDR = ADDRW'(tpuv2_pkg::STAT_ADDR)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADDRW-1:0] addr,
   input  logic             r_w,
   input  logic [DATAW-1:0] dataIn,
   input  logic             idle,
   input  logic             busy,
   input  logic             done,
   output logic             start,
   output logic [7:0]       k,
   output logic             acc,
   output logic [DATAW-1:0] stat_data,
   output logic             stat_valid
);
   import tpuv2_pkg::*;

   localparam logic [8:0] KMAX = 9'(MAX_K);

   logic             wr_ctrl;
   logic             rd_stat;
   logic [7:0]       wr_k;
   logic             wr_acc;
   logic             accept;
   logic             done_st;
   logic             err_st;
   logic [DATAW-1:0] stat_word;
   logic             unused_ok;

   assign wr_ctrl = r_w && (addr == CTRL_ADDR);
   assign rd_stat = !r_w && (addr == STAT_ADDR);
   assign wr_k    = dataIn[CTRL_K_LSB +: CTRL_K_W];
   assign wr_acc  = dataIn[CTRL_ACC_BIT];

   // a start already latched but not yet seen by the FSM counts as busy
   assign accept = wr_ctrl && idle && !start
                && (wr_k != 8'd0) && ({1'b0, wr_k} <= KMAX);

   assign unused_ok = ^dataIn[DATAW-1:CTRL_ACC_BIT+1];

   always_comb begin
      stat_word                    = '0;
      stat_word[K_LSB +: K_W]      = k;
      stat_word[ACC_BIT]           = acc;
      stat_word[BUSY_BIT]          = busy;
      stat_word[DONE_BIT]          = done_st;
      stat_word[ERR_BIT]           = err_st;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         start      <= 1'b0;
         k          <= 8'd1;
         acc        <= 1'b0;
         done_st    <= 1'b0;
         err_st     <= 1'b0;
         stat_data  <= '0;
         stat_valid <= 1'b0;
      end else begin
         start      <= accept;
         stat_valid <= rd_stat;
         stat_data  <= rd_stat ? stat_word : '0;
         if (accept) begin
            k   <= wr_k;
            acc <= wr_acc;
         end
         // completion beats a simultaneous status-read clear
         if (done)
            done_st <= 1'b1;
         else if (accept || rd_stat)
            done_st <= 1'b0;
         if (wr_ctrl && !accept)
            err_st <= 1'b1;
         else if (rd_stat)
            err_st <= 1'b0;
      end
   end

endmodule

// File: rtl/tpuv2_seq.sv
// tpuv2 compute sequencer: IDLE/CLEAR/RUN/DONE FSM issuing array strobes.
// Ports: clk, rst (sync, high); MMIO addr/r_w/dataIn; stat_data/stat_valid;
// c_clear, sa_en, feed_step, feed_valid, busy, done (all registered).
module tpuv2_seq #(
   parameter int                DIM       = 8,
   parameter int                ADDRW     = 16,
   parameter int                DATAW     = 64,
   parameter int                MAX_K     = 64,
   parameter logic [ADDRW-1:0]  CTRL_ADDR = ADDRW'(tpuv2_pkg::CTRL_ADDR),
   parameter logic [ADDRW-1:0]  STAT_ADDR = ADDRW'(tpuv2_pkg::STAT_ADDR)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [ADDRW-1:0]                  addr,
   input  logic                              r_w,
   input  logic [DATAW-1:0]                  dataIn,
   output logic [DATAW-1:0]                  stat_data,
   output logic                              stat_valid,
   output logic                              c_clear,
   output logic                              sa_en,
   output logic [$clog2(MAX_K+2*DIM)-1:0]    feed_step,
   output logic                              feed_valid,
   output logic                              busy,
   output logic                              done
);
   import tpuv2_pkg::*;

   localparam int            SW  = $clog2(MAX_K+2*DIM);
   localparam logic [SW-1:0] OFS = SW'(2*DIM-3);

   state_t        state;
   logic          start;
   logic [7:0]    k_q;
   logic          acc_q;
   logic          idle;
   logic [SW-1:0] k_s;
   logic [SW-1:0] last;
   logic [SW-1:0] step_nx;
   logic          unused_k;

   assign idle     = (state == IDLE);
   assign k_s      = SW'(k_q);
   assign last     = k_s + OFS;
   assign step_nx  = feed_step + SW'(1);
   assign unused_k = ^k_q;

   tpuv2_mmio_regs #(
      .ADDRW     (ADDRW),
      .DATAW     (DATAW),
      .MAX_K     (MAX_K),
      .CTRL_ADDR (CTRL_ADDR),
      .STAT_ADDR (STAT_ADDR)
   ) u_regs (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .r_w        (r_w),
      .dataIn     (dataIn),
      .idle       (idle),
      .busy       (busy),
      .done       (done),
      .start      (start),
      .k          (k_q),
      .acc        (acc_q),
      .stat_data  (stat_data),
      .stat_valid (stat_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         c_clear    <= 1'b0;
         sa_en      <= 1'b0;
         feed_step  <= '0;
         feed_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         c_clear <= 1'b0;
         done    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (acc_q) begin
                     state      <= RUN;
                     sa_en      <= 1'b1;
                     feed_step  <= '0;
                     feed_valid <= 1'b1;
                  end else begin
                     state   <= CLEAR;
                     c_clear <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               state      <= RUN;
               sa_en      <= 1'b1;
               feed_step  <= '0;
               feed_valid <= 1'b1;
            end
            RUN: begin
               if (feed_step == last) begin
                  state      <= DONE;
                  sa_en      <= 1'b0;
                  feed_step  <= '0;
                  feed_valid <= 1'b0;
                  done       <= 1'b1;
               end else begin
                  feed_step  <= step_nx;
                  feed_valid <= (step_nx < k_s);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/tpuv2_seq.md
Name: tpuv2_seq

Overview:
- Compute sequencer for the second-generation TPU AFU. Sits between the MMIO bus (addr/r_w/dataIn) and the A/B operand buffers, the DIM×DIM systolic array and the C buffer.
- Replaces tpuv1's fixed single-shot start at 0x400 with a configurable reduction depth K, an accumulate/overwrite mode, sticky status flags and a readable status register.
- The sequencer only issues control strobes. Operand skew stays inside the buffers.

Parameters:
- DIM, 8, systolic array dimension.
- ADDRW, 16, MMIO address width.
- DATAW, 64, MMIO data width.
- MAX_K, 64, largest accepted reduction depth (number of A/B rows fed).
- CTRL_ADDR, 'h400, write-only control register address.
- STAT_ADDR, 'h408, read-only status register address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDRW  MMIO address.
- r_w  in  1  1 = write, 0 = read.
- dataIn  in  DATAW  MMIO write data.
- stat_data  out  DATAW  status word; valid when stat_valid = 1.
- stat_valid  out  1  one-cycle pulse, the cycle after a status read.
- c_clear  out  1  one-cycle pulse; zero all C accumulators.
- sa_en  out  1  advance the array and the A/B buffers this cycle.
- feed_step  out  $clog2(MAX_K+2*DIM)  step index during RUN.
- feed_valid  out  1  feed_step < K (real operand row, not a zero flush).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the computation completes.

Behaviour:
- Reset: state IDLE. All outputs 0; sticky flags 0; K register = 1; acc register = 0.
- Control write: r_w=1 & addr==CTRL_ADDR.
  - dataIn[7:0] = K.
  - dataIn[8] = acc (1 = accumulate into existing C, 0 = clear C first).
- Start is accepted only when IDLE and 1 ≤ K ≤ MAX_K.
  - On accept at edge n: latch K and acc, clear done_sticky.
  - If acc=0 → CLEAR; if acc=1 → RUN.
- Start is rejected when busy, or when K=0 or K>MAX_K.
  - err_sticky is set; no other state changes; no partial latch of K or acc.
- CLEAR: lasts 1 cycle with c_clear=1, then → RUN.
- RUN: lasts K+2*DIM-2 cycles.
  - sa_en=1 throughout.
  - feed_step counts 0 .. K+2*DIM-3.
  - feed_valid = (feed_step < K).
  - After the last step → DONE.
- DONE: lasts 1 cycle with done=1 and done_sticky set, then → IDLE.
- Latency, start edge n to done high:
  - acc=0: cycle n+K+2*DIM.
  - acc=1: cycle n+K+2*DIM-1.
  - For DIM=8, K=8, acc=0, done is high in cycle n+24.
- Status read: r_w=0 & addr==STAT_ADDR.
  - In the next cycle stat_valid=1 and stat_data = {zeros, err_sticky[11], done_sticky[10], busy[9], acc[8], K[7:0]}.
  - The value is sampled in the read cycle.
  - The read clears done_sticky and err_sticky on the same edge.
  - A status read in the same cycle as done: the returned word shows done_sticky=0, and the flag still ends up set, because the set wins over the clear.
- The control write and the status read are mutually exclusive by r_w. All other addresses are ignored.
- Reset mid-RUN/CLEAR: return to IDLE next edge; no done pulse; flags cleared.
- feed_step width must hold MAX_K+2*DIM-3 without wrap. The counter does not wrap within a run.

Decomposition:
- Package tpuv2_pkg holds:
  - the state enum {IDLE, CLEAR, RUN, DONE};
  - CTRL_ADDR and STAT_ADDR;
  - the status-bit index localparams (K_LSB, ACC_BIT, BUSY_BIT, DONE_BIT, ERR_BIT);
  - the ctrl-word field positions.
- One sub-module, tpuv2_mmio_regs: address decode, K/acc latch, sticky flags, registered status read. The FSM and step counter stay in tpuv2_seq.

Test Plan:
- Reset, then read STAT_ADDR → stat_valid a cycle later, stat_data = 'h001; busy=0, done=0.
- Write CTRL 'h008 (K=8, acc=0) at edge n → c_clear in n+1; sa_en for 22 cycles; feed_valid for the first 8; done in n+24; status read then = 'h408.
- Write CTRL 'h108 (K=8, acc=1) → no c_clear; done in n+23; sa_en count = 22.
- Write CTRL during RUN with K=3 → ignored; run completes with the original K; status shows err (bit 11) and done set; the next status read returns 'h008.
- Write K=0 while idle, and separately K=MAX_K+1 → busy stays 0; err set; no sa_en.
- Assert rst in the 5th RUN cycle → next cycle busy=0, sa_en=0, no done; status = 'h001.
